// File: rtl/cv32e40p_if_id_queue.sv
// Instruction queue between the fetch aligner/compressed decoder and the ID stage.
// It is a circular buffer of DEPTH entries and can optionally forward an instruction straight through when empty.
module cv32e40p_if_id_queue #(
    parameter  int DEPTH        = 2,
    parameter  int FALL_THROUGH = 0,
    localparam int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      in_instr_i,
    input  logic [31:0]      in_pc_i,
    input  logic             in_compressed_i,
    input  logic             in_illegal_c_i,

    input  logic             halt_i,
    input  logic             clear_i,

    output logic             instr_valid_id_o,
    input  logic             id_ready_i,
    output logic [31:0]      instr_rdata_id_o,
    output logic [31:0]      pc_id_o,
    output logic             is_compressed_id_o,
    output logic             illegal_c_insn_id_o,

    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             perf_stall_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam bit FT_EN = (FALL_THROUGH != 0);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        compressed;
        logic        illegal;
    } entry_t;

    entry_t           mem_q [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;

    entry_t in_entry;
    entry_t head;
    logic   ft_active;
    logic   bypass;
    logic   push;
    logic   pop;
    logic   wr_en;
    logic   rd_en;

    // Wrap is explicit so that non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign in_entry = '{instr: in_instr_i, pc: in_pc_i,
                        compressed: in_compressed_i, illegal: in_illegal_c_i};

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CNT_W'(DEPTH));
    assign count_o   = count_q;

    assign ft_active = FT_EN && empty_o && in_valid_i && !halt_i && !clear_i;
    assign bypass    = ft_active && id_ready_i;

    assign instr_valid_id_o = !empty_o || ft_active;

    // A full queue is never empty, so this avoids any dependence on in_valid_i.
    assign in_ready_o   = !halt_i && !clear_i && (!full_o || (!empty_o && id_ready_i));
    assign perf_stall_o = in_valid_i && !in_ready_o && !halt_i && !clear_i;

    assign push  = in_valid_i && in_ready_o;
    assign pop   = instr_valid_id_o && id_ready_i && !clear_i;
    assign wr_en = push && !bypass;
    assign rd_en = pop && !bypass;

    always_comb begin
        head = mem_q[rd_ptr_q];
        if (ft_active) begin
            head = in_entry;
        end
    end

    assign instr_rdata_id_o    = head.instr;
    assign pc_id_o             = head.pc;
    assign is_compressed_id_o  = head.compressed;
    assign illegal_c_insn_id_o = head.illegal;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) begin
                mem_q[wr_ptr_q] <= in_entry;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (rd_en) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            if (wr_en && !rd_en) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!wr_en && rd_en) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_cv32e40p_if_id_queue.sv
// Scoreboard bench for cv32e40p_if_id_queue.
// It runs three instances: DEPTH=2, DEPTH=3, and DEPTH=2 with fall-through.
module tb_cv32e40p_if_id_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [31:0] instr_in  [3];
    logic [31:0] pc_in     [3];
    logic        comp_in   [3];
    logic        ill_in    [3];
    logic        halt      [3];
    logic        clear     [3];
    logic        ivalid    [3];
    logic        id_ready  [3];
    logic [31:0] instr_id  [3];
    logic [31:0] pc_id     [3];
    logic        comp_id   [3];
    logic        ill_id    [3];
    logic [1:0]  count     [3];
    logic        full      [3];
    logic        empty     [3];
    logic        perf      [3];

    typedef struct {
        int          idx;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        c;
        logic        il;
    } exp_t;

    exp_t exp_q [$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        cv32e40p_if_id_queue #(
            .DEPTH        ((g == 1) ? 3 : 2),
            .FALL_THROUGH ((g == 2) ? 1 : 0)
        ) u_dut (
            .clk                 (clk),
            .rst_n               (rst_n),
            .in_valid_i          (in_valid[g]),
            .in_ready_o          (in_ready[g]),
            .in_instr_i          (instr_in[g]),
            .in_pc_i             (pc_in[g]),
            .in_compressed_i     (comp_in[g]),
            .in_illegal_c_i      (ill_in[g]),
            .halt_i              (halt[g]),
            .clear_i             (clear[g]),
            .instr_valid_id_o    (ivalid[g]),
            .id_ready_i          (id_ready[g]),
            .instr_rdata_id_o    (instr_id[g]),
            .pc_id_o             (pc_id[g]),
            .is_compressed_id_o  (comp_id[g]),
            .illegal_c_insn_id_o (ill_id[g]),
            .count_o             (count[g]),
            .full_o              (full[g]),
            .empty_o             (empty[g]),
            .perf_stall_o        (perf[g])
        );
    end

    function automatic logic [31:0] instr_of(input logic [31:0] pc);
        return {pc[23:0], 8'h13};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    task automatic offer(input int g, input logic [31:0] pc);
        in_valid[g] = 1'b1;
        pc_in[g]    = pc;
        instr_in[g] = instr_of(pc);
        comp_in[g]  = pc[2];
        ill_in[g]   = pc[3];
    endtask

    task automatic expect_pop(input int g, input logic [31:0] pc);
        exp_t e;
        e.idx   = g;
        e.pc    = pc;
        e.instr = instr_of(pc);
        e.c     = pc[2];
        e.il    = pc[3];
        exp_q.push_back(e);
    endtask

    task automatic clk_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic chk_reset(input int g);
        chk("rst_valid", 32'(ivalid[g]), 0);
        chk("rst_instr", instr_id[g], 0);
        chk("rst_pc", pc_id[g], 0);
        chk("rst_comp", 32'(comp_id[g]), 0);
        chk("rst_ill", 32'(ill_id[g]), 0);
        chk("rst_count", 32'(count[g]), 0);
        chk("rst_full", 32'(full[g]), 0);
        chk("rst_empty", 32'(empty[g]), 1);
        chk("rst_perf", 32'(perf[g]), 0);
        chk("rst_ready", 32'(in_ready[g]), 1);
    endtask

    // Monitor: every consumed head is compared against the oldest expectation.
    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (rst_n && ivalid[g] && id_ready[g] && !clear[g]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL pop_unexpected: dut%0d gave pc 0x%0h, want no pop", g, pc_id[g]);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (e.idx != g || e.pc !== pc_id[g] || e.instr !== instr_id[g] ||
                        e.c !== comp_id[g] || e.il !== ill_id[g]) begin
                        errors++;
                        $display("FAIL pop_data: dut%0d got pc 0x%0h instr 0x%0h c%0b i%0b, want dut%0d pc 0x%0h instr 0x%0h c%0b i%0b",
                                 g, pc_id[g], instr_id[g], comp_id[g], ill_id[g],
                                 e.idx, e.pc, e.instr, e.c, e.il);
                    end
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        for (int g = 0; g < 3; g++) begin
            in_valid[g] = 1'b0; pc_in[g] = '0; instr_in[g] = '0; comp_in[g] = 1'b0;
            ill_in[g] = 1'b0; halt[g] = 1'b0; clear[g] = 1'b0; id_ready[g] = 1'b0;
        end
        clk_edge();
        clk_edge();
        rst_n = 1'b1;
        settle();
        for (int g = 0; g < 3; g++) chk_reset(g);

        // Fill/drain, DEPTH=2
        clk_edge();
        offer(0, 32'h80); expect_pop(0, 32'h80);
        clk_edge();
        offer(0, 32'h84); expect_pop(0, 32'h84);
        clk_edge();
        offer(0, 32'h88); expect_pop(0, 32'h88);
        settle();
        chk("fill_count", 32'(count[0]), 2);
        chk("fill_full", 32'(full[0]), 1);
        chk("fill_ready", 32'(in_ready[0]), 0);
        chk("fill_stall", 32'(perf[0]), 1);
        clk_edge();
        id_ready[0] = 1'b1;
        settle();
        chk("full_pushpop_ready", 32'(in_ready[0]), 1);
        clk_edge();
        in_valid[0] = 1'b0;
        clk_edge();
        clk_edge();
        id_ready[0] = 1'b0;
        settle();
        chk("drain_empty", 32'(empty[0]), 1);
        chk("drain_valid", 32'(ivalid[0]), 0);

        // Push and pop at full, DEPTH=3
        clk_edge();
        for (int i = 0; i < 3; i++) begin
            offer(1, 32'h100 + 32'(4 * i)); expect_pop(1, 32'h100 + 32'(4 * i));
            clk_edge();
        end
        in_valid[1] = 1'b0;
        settle();
        chk("d3_full", 32'(full[1]), 1);
        for (int i = 0; i < 10; i++) begin
            clk_edge();
            offer(1, 32'h10C + 32'(4 * i)); expect_pop(1, 32'h10C + 32'(4 * i));
            id_ready[1] = 1'b1;
            settle();
            chk("d3_count_steady", 32'(count[1]), 3);
            chk("d3_ready", 32'(in_ready[1]), 1);
        end
        clk_edge();
        in_valid[1] = 1'b0;
        clk_edge();
        clk_edge();
        clk_edge();
        id_ready[1] = 1'b0;
        settle();
        chk("d3_empty", 32'(empty[1]), 1);

        // Flush with simultaneous push and pop request
        clk_edge();
        offer(0, 32'h300); expect_pop(0, 32'h300);
        clk_edge();
        offer(0, 32'h304); expect_pop(0, 32'h304);
        clk_edge();
        offer(0, 32'h308);
        clear[0] = 1'b1; id_ready[0] = 1'b1;
        settle();
        chk("flush_ready", 32'(in_ready[0]), 0);
        chk("flush_stall", 32'(perf[0]), 0);
        clk_edge();
        exp_q.delete();
        clear[0] = 1'b0; id_ready[0] = 1'b0; in_valid[0] = 1'b0;
        settle();
        chk("flush_count", 32'(count[0]), 0);
        chk("flush_valid", 32'(ivalid[0]), 0);
        clk_edge();
        offer(0, 32'h1000); expect_pop(0, 32'h1000);
        clk_edge();
        in_valid[0] = 1'b0;
        settle();
        chk("flush_head", pc_id[0], 32'h1000);
        clk_edge();
        id_ready[0] = 1'b1;
        clk_edge();
        id_ready[0] = 1'b0;

        // Halt blocks pushes while ID drains
        offer(0, 32'h400); expect_pop(0, 32'h400);
        clk_edge();
        offer(0, 32'h404); expect_pop(0, 32'h404);
        clk_edge();
        offer(0, 32'h408);
        halt[0] = 1'b1; id_ready[0] = 1'b1;
        settle();
        chk("halt_ready", 32'(in_ready[0]), 0);
        chk("halt_stall", 32'(perf[0]), 0);
        clk_edge();
        clk_edge();
        settle();
        chk("halt_drained", 32'(empty[0]), 1);
        clk_edge();
        halt[0] = 1'b0; id_ready[0] = 1'b0; in_valid[0] = 1'b0;

        // Fall-through, empty queue
        offer(2, 32'h200); expect_pop(2, 32'h200);
        id_ready[2] = 1'b1;
        settle();
        chk("ft_valid", 32'(ivalid[2]), 1);
        chk("ft_pc", pc_id[2], 32'h200);
        chk("ft_instr", instr_id[2], instr_of(32'h200));
        clk_edge();
        offer(2, 32'h204); expect_pop(2, 32'h204);
        id_ready[2] = 1'b0;
        settle();
        chk("ft_count_bypass", 32'(count[2]), 0);
        chk("ft_mirror_pc", pc_id[2], 32'h204);
        clk_edge();
        in_valid[2] = 1'b0;
        settle();
        chk("ft_count_stored", 32'(count[2]), 1);
        chk("ft_stored_pc", pc_id[2], 32'h204);
        clk_edge();
        id_ready[2] = 1'b1;
        clk_edge();
        id_ready[2] = 1'b0;

        // Reset in the middle of operation
        offer(0, 32'h500);
        clk_edge();
        offer(0, 32'h50C);
        clk_edge();
        in_valid[0] = 1'b0;
        settle();
        chk("prerst_count", 32'(count[0]), 2);
        clk_edge();
        rst_n = 1'b0;
        clk_edge();
        rst_n = 1'b1;
        settle();
        chk_reset(0);
        clk_edge();
        id_ready[0] = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            chk("postrst_valid", 32'(ivalid[0]), 0);
            clk_edge();
        end
        offer(0, 32'h600); expect_pop(0, 32'h600);
        clk_edge();
        in_valid[0] = 1'b0;
        clk_edge();
        id_ready[0] = 1'b0;
        settle();
        chk("postrst_empty", 32'(empty[0]), 1);

        chk("exp_q_drained", 32'(exp_q.size()), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cv32e40p_if_id_queue.md
# cv32e40p_if_id_queue

Parametrised instruction queue that replaces the single-entry IF/ID pipeline register between the fetch stage (aligner plus compressed decoder) and the ID stage. It holds up to DEPTH decoded instructions with their PC and compressed/illegal flags. This lets fetch keep running while ID stalls. Whole-queue flush is used on PC redirects, and an optional fall-through mode gives zero-latency forwarding when the queue is empty.

## Interface
Parameters:
- DEPTH, 2, number of entries; any integer >= 1, non-power-of-two allowed.
- FALL_THROUGH, 0, 1 = an empty queue forwards the input to the outputs combinationally in the same cycle.
- CNT_W, $clog2(DEPTH+1), width of count_o; derived, not overridden.

Ports (one clock; reset is synchronous and active-low):
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid_i  input  1  fetch side offers an instruction.
- in_ready_o  output  1  queue accepts it this cycle.
- in_instr_i  input  32  decompressed instruction.
- in_pc_i  input  32  PC of the instruction.
- in_compressed_i  input  1  original instruction was RVC.
- in_illegal_c_i  input  1  compressed decoder flagged the instruction as illegal.
- halt_i  input  1  blocks pushes; the equivalent of halt_if.
- clear_i  input  1  flush; asserted with pc_set.
- instr_valid_id_o  output  1  head entry valid.
- id_ready_i  input  1  ID consumes the head this cycle.
- instr_rdata_id_o  output  32  head instruction.
- pc_id_o  output  32  head PC.
- is_compressed_id_o  output  1  head compressed flag.
- illegal_c_insn_id_o  output  1  head illegal-compressed flag.
- count_o  output  CNT_W  occupancy.
- full_o  output  1  count_o == DEPTH.
- empty_o  output  1  count_o == 0.
- perf_stall_o  output  1  in_valid_i asserted but not accepted, excluding halt_i and clear_i cycles.

## Operation
- Storage: circular buffer of DEPTH entries, each 66 bits (instr, pc, compressed, illegal). Read pointer, write pointer and count are registered.
- Pointers increment modulo DEPTH; wrap from DEPTH-1 to 0 explicitly, never by natural overflow.
- push = in_valid_i & in_ready_o.
- in_ready_o = !halt_i & !clear_i & (!full_o | (instr_valid_id_o & id_ready_i)). Push into a full queue is allowed when a pop happens in the same cycle.
- pop = instr_valid_id_o & id_ready_i & !clear_i.
- count next value:
  - push without pop: +1.
  - pop without push: -1.
  - both or neither: unchanged.
- Outputs show the entry at the read pointer. instr_valid_id_o = !empty_o (FALL_THROUGH=0).
- FALL_THROUGH=1, queue empty, in_valid_i & !halt_i & !clear_i:
  - instr_valid_id_o = 1 and the outputs mirror the in_* inputs.
  - If id_ready_i is also high, the instruction is consumed directly: not written, count stays 0, pointers unchanged.
  - Otherwise it is written as a normal push.
- clear_i has priority over everything:
  - Next cycle: count = 0 and read pointer = write pointer = 0.
  - The same-cycle push and pop are suppressed.
  - Storage contents are not required to be cleared.
- halt_i only blocks pushes; pops continue, so ID drains the queue.
- Reset (rst_n low at a clock edge):
  - Pointers and count go to 0, and all storage is zeroed.
  - Output reset values: instr_valid_id_o=0, instr_rdata_id_o=0, pc_id_o=0, is_compressed_id_o=0, illegal_c_insn_id_o=0, count_o=0, full_o=0, empty_o=1, perf_stall_o=0.
  - in_ready_o=1 once rst_n is high, provided halt_i and clear_i are low.
  - Reset asserted mid-operation discards all entries, with the same result as clear_i.
- When empty with FALL_THROUGH=0, the data outputs hold the last read-pointer entry. ID must qualify them with instr_valid_id_o.

## Timing
- FALL_THROUGH=0: push in cycle N is visible at the outputs in cycle N+1 (1-cycle latency). FALL_THROUGH=1: 0 cycles when empty.
- Throughput: 1 push plus 1 pop per cycle sustained at every occupancy, including full.
- Combinational paths:
  - id_ready_i -> in_ready_o.
  - FALL_THROUGH=1 only: in_* -> *_id_o.
  - No path from in_valid_i to in_ready_o.
- Flush latency: clear_i in cycle N -> instr_valid_id_o=0 in cycle N+1. A push in N+1 is visible in N+2, or in N+1 with fall-through.
- The status outputs full_o, empty_o and count_o are registered-state decodes that reflect the start of the cycle.

## Test plan
- Fill/drain, DEPTH=2, FALL_THROUGH=0: push PCs 0x80, 0x84, 0x88 with id_ready_i=0 -> first two accepted, full_o=1, in_ready_o=0, perf_stall_o=1 on the third. Then id_ready_i=1 -> pops in order 0x80, 0x84, 0x88.
- Simultaneous push/pop at full, DEPTH=3: hold count=3, push and pop every cycle for 10 cycles -> count stays 3, in-order PCs, pointer wrap exercised (non-power-of-two).
- Flush: count=2 with clear_i=1 together with in_valid_i and id_ready_i -> neither accepted nor consumed; next cycle count=0, instr_valid_id_o=0. Push 0x1000 -> head 0x1000.
- Halt: count=2, halt_i=1, in_valid_i=1, id_ready_i=1 -> in_ready_o=0 and perf_stall_o=0. Queue drains to empty in 2 cycles.
- Fall-through, FALL_THROUGH=1, empty: in_valid_i=1, pc 0x200, id_ready_i=1 -> same-cycle instr_valid_id_o=1, pc_id_o=0x200; count stays 0. Repeat with id_ready_i=0 -> count=1 next cycle.
- Reset mid-operation: count=2, rst_n=0 for one edge -> all outputs at their reset values; an old entry never reappears after reset.
